// File: rtl/board_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : board_tracker
//  Description : Battleship board bookkeeping. Validates fleet placement
//                during setup, then resolves shots one at a time, keeping
//                fired/hit bitmaps, per-ship hit counters and sunk status.
//  Revision    : 1.0  initial release
// ============================================================================
module board_tracker (
  input  logic         clk,
  input  logic         rst,
  input  logic         place_valid,
  input  logic [2:0]   place_ship,
  input  logic [3:0]   place_x,
  input  logic [3:0]   place_y,
  input  logic         place_vert,
  output logic         place_ok,
  output logic         place_err,
  input  logic         start,
  input  logic         shot_valid,
  output logic         shot_ready,
  input  logic [3:0]   shot_x,
  input  logic [3:0]   shot_y,
  output logic         res_valid,
  output logic         res_hit,
  output logic         res_sunk,
  output logic         res_repeat,
  output logic         res_illegal,
  output logic [2:0]   res_ship,
  output logic [99:0]  fired,
  output logic [99:0]  hits,
  output logic [4:0]   ships_alive,
  output logic         all_sunk
);

  localparam int         NUM_CELLS = 100;
  localparam int         NUM_SHIPS = 5;
  localparam logic [2:0] EMPTY     = 3'd7;

  typedef enum logic [1:0] {
    SETUP   = 2'd0,
    PLAY    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Ship length by id; unknown ids have length zero.
  function automatic logic [2:0] ship_len(input logic [2:0] id);
    logic [2:0] len;
    case (id)
      3'd0:       len = 3'd2;
      3'd1, 3'd2: len = 3'd3;
      3'd3:       len = 3'd4;
      3'd4:       len = 3'd5;
      default:    len = 3'd0;
    endcase
    return len;
  endfunction

  // One-hot ship mask; ids above 4 give an all-zero mask.
  function automatic logic [4:0] ship_onehot(input logic [2:0] id);
    logic [4:0] oh;
    for (int k = 0; k < NUM_SHIPS; k++) begin
      oh[k] = (id == 3'(k));
    end
    return oh;
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          map_q [NUM_CELLS];
  logic [2:0]          map_d [NUM_CELLS];
  logic [4:0]          placed_q, placed_d;
  logic [4:0]          alive_q, alive_d;
  logic [4:0][2:0]     cnt_q, cnt_d;
  logic [99:0]         fired_q, fired_d;
  logic [99:0]         hits_q, hits_d;
  logic [3:0]          sx_q, sx_d;
  logic [3:0]          sy_q, sy_d;
  logic                place_ok_q, place_ok_d;
  logic                place_err_q, place_err_d;
  logic                shot_ready_q, shot_ready_d;
  logic                res_valid_q, res_valid_d;
  logic                res_hit_q, res_hit_d;
  logic                res_sunk_q, res_sunk_d;
  logic                res_repeat_q, res_repeat_d;
  logic                res_illegal_q, res_illegal_d;
  logic [2:0]          res_ship_q, res_ship_d;
  logic                all_sunk_q, all_sunk_d;

  logic                place_take;
  logic                place_good;
  logic [2:0]          place_len;
  logic [6:0]          place_idx [NUM_SHIPS];
  logic                shot_illegal;
  logic [6:0]          shot_idx;
  logic [2:0]          shot_cell;

  // A request is only looked at in SETUP and not while a result pulse is out.
  assign place_take = (state_q == SETUP) && place_valid && !place_ok_q && !place_err_q;

  // Check every cell the requested ship would cover: on-board and empty.
  always_comb begin
    logic [4:0] cx;
    logic [4:0] cy;
    place_len  = ship_len(place_ship);
    place_good = (place_ship <= 3'd4) && ((placed_q & ship_onehot(place_ship)) == 5'd0);
    for (int i = 0; i < NUM_SHIPS; i++) begin
      cx = {1'b0, place_x} + (place_vert ? 5'd0 : 5'(i));
      cy = {1'b0, place_y} + (place_vert ? 5'(i) : 5'd0);
      place_idx[i] = 7'd0;
      if (3'(i) < place_len) begin
        if ((cx > 5'd9) || (cy > 5'd9)) begin
          place_good = 1'b0;
        end else begin
          place_idx[i] = ({2'b00, cy} * 7'd10) + {2'b00, cx};
          if (map_q[place_idx[i]] != EMPTY) begin
            place_good = 1'b0;
          end
        end
      end
    end
  end

  // Decode the captured shot; off-board shots never read a real cell.
  always_comb begin
    shot_illegal = (sx_q > 4'd9) || (sy_q > 4'd9);
    shot_idx     = ({3'b000, sy_q} * 7'd10) + {3'b000, sx_q};
    shot_cell    = shot_illegal ? EMPTY : map_q[shot_idx];
  end

  // Next-state, placement bookkeeping and shot resolution.
  always_comb begin
    state_d       = state_q;
    map_d         = map_q;
    placed_d      = placed_q;
    alive_d       = alive_q;
    cnt_d         = cnt_q;
    fired_d       = fired_q;
    hits_d        = hits_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    place_ok_d    = 1'b0;
    place_err_d   = 1'b0;
    res_valid_d   = 1'b0;
    res_hit_d     = 1'b0;
    res_sunk_d    = 1'b0;
    res_repeat_d  = 1'b0;
    res_illegal_d = 1'b0;
    res_ship_d    = EMPTY;

    case (state_q)
      SETUP: begin
        if (place_take) begin
          if (place_good) begin
            place_ok_d = 1'b1;
            placed_d   = placed_q | ship_onehot(place_ship);
            alive_d    = alive_q | ship_onehot(place_ship);
            for (int i = 0; i < NUM_SHIPS; i++) begin
              if (3'(i) < place_len) begin
                map_d[place_idx[i]] = place_ship;
              end
            end
          end else begin
            place_err_d = 1'b1;
          end
        end
        if (start && (placed_q == 5'h1F)) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (shot_valid && shot_ready_q) begin
          sx_d    = shot_x;
          sy_d    = shot_y;
          state_d = RESOLVE;
        end
      end

      RESOLVE: begin
        res_valid_d = 1'b1;
        if (shot_illegal) begin
          res_illegal_d = 1'b1;
        end else if (fired_q[shot_idx]) begin
          // Repeat shots report the cell but never count twice.
          res_repeat_d = 1'b1;
          res_hit_d    = (shot_cell != EMPTY);
          res_ship_d   = shot_cell;
        end else begin
          fired_d[shot_idx] = 1'b1;
          if (shot_cell != EMPTY) begin
            hits_d[shot_idx]   = 1'b1;
            res_hit_d          = 1'b1;
            res_ship_d         = shot_cell;
            cnt_d[shot_cell]   = cnt_q[shot_cell] + 3'd1;
            if ((cnt_q[shot_cell] + 3'd1) == ship_len(shot_cell)) begin
              res_sunk_d = 1'b1;
              alive_d    = alive_q & ~ship_onehot(shot_cell);
            end
          end
        end
        state_d = (alive_d == 5'd0) ? DONE : PLAY;
      end

      default: begin
        state_d = DONE;
      end
    endcase

    shot_ready_d = (state_d == PLAY);
    all_sunk_d   = (state_d == DONE);
  end

  // State register with synchronous reset to an empty board.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SETUP;
      for (int i = 0; i < NUM_CELLS; i++) begin
        map_q[i] <= EMPTY;
      end
      placed_q      <= 5'd0;
      alive_q       <= 5'd0;
      cnt_q         <= '0;
      fired_q       <= 100'd0;
      hits_q        <= 100'd0;
      sx_q          <= 4'd0;
      sy_q          <= 4'd0;
      place_ok_q    <= 1'b0;
      place_err_q   <= 1'b0;
      shot_ready_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_hit_q     <= 1'b0;
      res_sunk_q    <= 1'b0;
      res_repeat_q  <= 1'b0;
      res_illegal_q <= 1'b0;
      res_ship_q    <= EMPTY;
      all_sunk_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      map_q         <= map_d;
      placed_q      <= placed_d;
      alive_q       <= alive_d;
      cnt_q         <= cnt_d;
      fired_q       <= fired_d;
      hits_q        <= hits_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      place_ok_q    <= place_ok_d;
      place_err_q   <= place_err_d;
      shot_ready_q  <= shot_ready_d;
      res_valid_q   <= res_valid_d;
      res_hit_q     <= res_hit_d;
      res_sunk_q    <= res_sunk_d;
      res_repeat_q  <= res_repeat_d;
      res_illegal_q <= res_illegal_d;
      res_ship_q    <= res_ship_d;
      all_sunk_q    <= all_sunk_d;
    end
  end

  assign place_ok    = place_ok_q;
  assign place_err   = place_err_q;
  assign shot_ready  = shot_ready_q;
  assign res_valid   = res_valid_q;
  assign res_hit     = res_hit_q;
  assign res_sunk    = res_sunk_q;
  assign res_repeat  = res_repeat_q;
  assign res_illegal = res_illegal_q;
  assign res_ship    = res_ship_q;
  assign fired       = fired_q;
  assign hits        = hits_q;
  assign ships_alive = alive_q;
  assign all_sunk    = all_sunk_q;

endmodule
`default_nettype wire

// File: tb/tb_board_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_board_tracker
//  Description : Directed, table-driven bench for board_tracker: placement
//                table, shot table with a fired/hit bitmap model, and
//                hand-written sequences for start gating, end of game,
//                placement turnaround and reset during resolve.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_board_tracker;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         place_valid = 1'b0;
  logic [2:0]   place_ship = 3'd0;
  logic [3:0]   place_x = 4'd0;
  logic [3:0]   place_y = 4'd0;
  logic         place_vert = 1'b0;
  logic         place_ok, place_err;
  logic         start = 1'b0;
  logic         shot_valid = 1'b0;
  logic         shot_ready;
  logic [3:0]   shot_x = 4'd0;
  logic [3:0]   shot_y = 4'd0;
  logic         res_valid, res_hit, res_sunk, res_repeat, res_illegal;
  logic [2:0]   res_ship;
  logic [99:0]  fired, hits;
  logic [4:0]   ships_alive;
  logic         all_sunk;

  board_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .place_valid (place_valid),
    .place_ship  (place_ship),
    .place_x     (place_x),
    .place_y     (place_y),
    .place_vert  (place_vert),
    .place_ok    (place_ok),
    .place_err   (place_err),
    .start       (start),
    .shot_valid  (shot_valid),
    .shot_ready  (shot_ready),
    .shot_x      (shot_x),
    .shot_y      (shot_y),
    .res_valid   (res_valid),
    .res_hit     (res_hit),
    .res_sunk    (res_sunk),
    .res_repeat  (res_repeat),
    .res_illegal (res_illegal),
    .res_ship    (res_ship),
    .fired       (fired),
    .hits        (hits),
    .ships_alive (ships_alive),
    .all_sunk    (all_sunk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ship;
    logic [3:0] x;
    logic [3:0] y;
    logic       vert;
    logic       ok;
    logic [4:0] alive;
  } place_vec_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       hit;
    logic       sunk;
    logic       rep;
    logic       ill;
    logic [2:0] ship;
    logic [4:0] alive;
  } shot_vec_t;

  place_vec_t  pv [11];
  shot_vec_t   sv [22];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [99:0] exp_fired = 100'd0;
  logic [99:0] exp_hits  = 100'd0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_place_ok"},   128'(place_ok),    128'(0));
    check({tag, "_place_err"},  128'(place_err),   128'(0));
    check({tag, "_shot_ready"}, 128'(shot_ready),  128'(0));
    check({tag, "_res_valid"},  128'(res_valid),   128'(0));
    check({tag, "_res_ship"},   128'(res_ship),    128'(7));
    check({tag, "_fired"},      128'(fired),       128'(0));
    check({tag, "_hits"},       128'(hits),        128'(0));
    check({tag, "_alive"},      128'(ships_alive), 128'(0));
    check({tag, "_all_sunk"},   128'(all_sunk),    128'(0));
  endtask

  task automatic do_place(input int id, input place_vec_t v);
    @(negedge clk);
    place_valid = 1'b1;
    place_ship  = v.ship;
    place_x     = v.x;
    place_y     = v.y;
    place_vert  = v.vert;
    @(posedge clk);
    #1;
    place_valid = 1'b0;
    check($sformatf("place%0d_ok", id),    128'(place_ok),    128'(v.ok));
    check($sformatf("place%0d_err", id),   128'(place_err),   128'(!v.ok));
    check($sformatf("place%0d_alive", id), 128'(ships_alive), 128'(v.alive));
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic exp_ready, input string name);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check(name, 128'(shot_ready), 128'(exp_ready));
  endtask

  // Drives one shot and waits (bounded) for its result; leaves sampling at
  // #1 after the edge that raised res_valid.
  task automatic do_shot(input int id, input logic [3:0] x, input logic [3:0] y, output logic got);
    int lat;
    @(negedge clk);
    check($sformatf("shot%0d_ready", id), 128'(shot_ready), 128'(1));
    shot_valid = 1'b1;
    shot_x     = x;
    shot_y     = y;
    @(posedge clk);
    #1;
    shot_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 4) begin
      @(posedge clk);
      #1;
      lat++;
      if (res_valid) got = 1'b1;
    end
    check($sformatf("shot%0d_latency", id), 128'(lat), 128'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic got;
    int   idx;

    // ship, x, y, vert, ok, alive-after
    pv[0]  = '{3'd4, 4'd5, 4'd0, 1'b0, 1'b1, 5'b10000};
    pv[1]  = '{3'd4, 4'd6, 4'd0, 1'b0, 1'b0, 5'b10000};
    pv[2]  = '{3'd3, 4'd6, 4'd0, 1'b0, 1'b0, 5'b10000};
    pv[3]  = '{3'd3, 4'd7, 4'd5, 1'b0, 1'b0, 5'b10000};
    pv[4]  = '{3'd0, 4'd0, 4'd0, 1'b0, 1'b1, 5'b10001};
    pv[5]  = '{3'd1, 4'd1, 4'd0, 1'b1, 1'b0, 5'b10001};
    pv[6]  = '{3'd1, 4'd9, 4'd8, 1'b1, 1'b0, 5'b10001};
    pv[7]  = '{3'd5, 4'd3, 4'd3, 1'b0, 1'b0, 5'b10001};
    pv[8]  = '{3'd1, 4'd0, 4'd2, 1'b0, 1'b1, 5'b10011};
    pv[9]  = '{3'd2, 4'd0, 4'd4, 1'b0, 1'b1, 5'b10111};
    pv[10] = '{3'd3, 4'd0, 4'd6, 1'b0, 1'b1, 5'b11111};

    // x, y, hit, sunk, repeat, illegal, ship, alive-after
    sv[0]  = '{4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'b11111};
    sv[1]  = '{4'd1,  4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'b11110};
    sv[2]  = '{4'd0,  4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 5'b11110};
    sv[3]  = '{4'd10, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 5'b11110};
    sv[4]  = '{4'd1,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 5'b11110};
    sv[5]  = '{4'd0,  4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 5'b11110};
    sv[6]  = '{4'd5,  4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 5'b11110};
    sv[7]  = '{4'd1,  4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 5'b11110};
    sv[8]  = '{4'd2,  4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 5'b11100};
    sv[9]  = '{4'd0,  4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 5'b11100};
    sv[10] = '{4'd1,  4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 5'b11100};
    sv[11] = '{4'd9,  4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 5'b11100};
    sv[12] = '{4'd2,  4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 5'b11000};
    sv[13] = '{4'd0,  4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 5'b11000};
    sv[14] = '{4'd1,  4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 5'b11000};
    sv[15] = '{4'd2,  4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 5'b11000};
    sv[16] = '{4'd3,  4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 5'b10000};
    sv[17] = '{4'd5,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 5'b10000};
    sv[18] = '{4'd6,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 5'b10000};
    sv[19] = '{4'd7,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 5'b10000};
    sv[20] = '{4'd8,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 5'b10000};
    sv[21] = '{4'd9,  4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 5'b00000};

    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    @(negedge clk);
    rst = 1'b0;

    // Placement table; start is tried once before the fleet is complete.
    for (int i = 0; i < 11; i++) begin
      if (i == 10) do_start(1'b0, "start_early_ready");
      do_place(i, pv[i]);
    end
    do_start(1'b1, "start_ready");

    // Shot table with a bitmap model of fired/hits.
    for (int i = 0; i < 22; i++) begin
      do_shot(i, sv[i].x, sv[i].y, got);
      if (got) begin
        if (!sv[i].ill && !sv[i].rep) begin
          idx = int'(sv[i].y) * 10 + int'(sv[i].x);
          exp_fired[idx] = 1'b1;
          if (sv[i].hit) exp_hits[idx] = 1'b1;
        end
        check($sformatf("shot%0d_hit", i),     128'(res_hit),     128'(sv[i].hit));
        check($sformatf("shot%0d_sunk", i),    128'(res_sunk),    128'(sv[i].sunk));
        check($sformatf("shot%0d_repeat", i),  128'(res_repeat),  128'(sv[i].rep));
        check($sformatf("shot%0d_illegal", i), 128'(res_illegal), 128'(sv[i].ill));
        check($sformatf("shot%0d_ship", i),    128'(res_ship),    128'(sv[i].ship));
        check($sformatf("shot%0d_alive", i),   128'(ships_alive), 128'(sv[i].alive));
        check($sformatf("shot%0d_fired", i),   128'(fired),       128'(exp_fired));
        check($sformatf("shot%0d_hits", i),    128'(hits),        128'(exp_hits));
      end
    end
    check("fired_count", 128'($countones(fired)), 128'(20));
    check("hits_count",  128'($countones(hits)),  128'(17));

    // End of game: DONE holds, further shots are ignored.
    check("done_all_sunk",   128'(all_sunk),   128'(1));
    check("done_shot_ready", 128'(shot_ready), 128'(0));
    @(negedge clk);
    shot_valid = 1'b1;
    shot_x     = 4'd4;
    shot_y     = 4'd4;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("done_ignore%0d_res_valid", c), 128'(res_valid), 128'(0));
    end
    shot_valid = 1'b0;
    check("done_fired_hold", 128'(fired),    128'(exp_fired));
    check("done_all_sunk2",  128'(all_sunk), 128'(1));

    // Reset out of DONE, re-place the fleet, then reset during RESOLVE.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("rst1");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (pv[i].ok) do_place(100 + i, pv[i]);
    end
    do_start(1'b1, "restart_ready");
    @(negedge clk);
    shot_valid = 1'b1;
    shot_x     = 4'd0;
    shot_y     = 4'd0;
    @(posedge clk);
    #1;
    shot_valid = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("rst2");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst2_quiet%0d_res_valid", c), 128'(res_valid), 128'(0));
    end

    // Placement turnaround: a request held for two cycles is taken once.
    @(negedge clk);
    place_valid = 1'b1;
    place_ship  = 3'd0;
    place_x     = 4'd0;
    place_y     = 4'd0;
    place_vert  = 1'b0;
    @(posedge clk);
    #1;
    check("turn_first_ok", 128'(place_ok), 128'(1));
    @(posedge clk);
    #1;
    place_valid = 1'b0;
    check("turn_second_ok",  128'(place_ok),    128'(0));
    check("turn_second_err", 128'(place_err),   128'(0));
    check("turn_alive",      128'(ships_alive), 128'(5'b00001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
